// File: rtl/gf_mult_seq.sv
// Sequential GF(2^WIDTH) multiplier: digit-serial Horner evaluation of A*B mod P(x),
// consuming DIGIT bits of A per cycle, MSB slice first.
module gf_mult_seq #(
  parameter int unsigned      WIDTH   = 128,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(128'h87),
  parameter int unsigned      DIGIT   = 8,
  parameter bit               REFLECT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             busy
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8 || DIGIT == 16) ||
      (WIDTH % DIGIT) != 0) begin : g_illegal_digit
    $error("gf_mult_seq: DIGIT must be 1, 2, 4, 8 or 16 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] z_step;
  logic [DIGIT-1:0] slice;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) r[i] = v[int'(WIDTH) - 1 - i];
    return r;
  endfunction

  // Map between port bit order and internal x^i-at-bit-i order (self-inverse).
  function automatic logic [WIDTH-1:0] orient(input logic [WIDTH-1:0] v);
    return REFLECT ? bit_rev(v) : v;
  endfunction

  assign slice = a_q[WIDTH-1 -: DIGIT];

  // One Horner step: Z*x^DIGIT + slice*B, reduced one bit at a time so every term is XOR-only.
  always_comb begin
    z_step = z_q;
    for (int i = int'(DIGIT) - 1; i >= 0; i--) begin
      z_step = {z_step[WIDTH-2:0], 1'b0} ^ (z_step[WIDTH-1] ? POLY : '0);
      if (slice[i]) z_step = z_step ^ b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      z_q       <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_z     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= orient(in_a);
            b_q      <= orient(in_b);
            z_q      <= '0;
            cnt_q    <= CNT_W'(STEPS);
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          if (abort) begin
            state    <= IDLE;
            cnt_q    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            z_q   <= z_step;
            a_q   <= a_q << DIGIT;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_z     <= orient(z_step);
            end
          end
        end
        DONE: begin
          // Abort wins over a simultaneous out_ready; either way the result is dropped here.
          if (abort || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_z     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_z     <= '0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mult_seq.sv
// Directed and randomised checks of gf_mult_seq: default instance for protocol,
// plus DIGIT=1/2/4/16 and REFLECT=1 instances for latency and bit order.
module tb_gf_mult_seq;

  localparam int unsigned W = 128;
  localparam logic [W-1:0] P = 128'h87;
  localparam logic [W-1:0] X127 = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [W-1:0] SQ127 = 128'hC000_0000_0000_0000_0000_0000_0000_1067;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic [W-1:0] in_a, in_b, out_z;

  logic         xv;
  logic [W-1:0] xa, xb, xra, xrb;
  logic         x_rdy [5];
  logic         x_ov [5];
  logic         x_busy [5];
  logic [W-1:0] x_z [5];

  int checks = 0;
  int errors = 0;

  gf_mult_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .busy(busy));

  gf_mult_seq #(.DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(xv), .in_ready(x_rdy[0]), .in_a(xa), .in_b(xb),
    .abort(1'b0), .out_valid(x_ov[0]), .out_ready(1'b1), .out_z(x_z[0]), .busy(x_busy[0]));
  gf_mult_seq #(.DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(xv), .in_ready(x_rdy[1]), .in_a(xa), .in_b(xb),
    .abort(1'b0), .out_valid(x_ov[1]), .out_ready(1'b1), .out_z(x_z[1]), .busy(x_busy[1]));
  gf_mult_seq #(.DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(xv), .in_ready(x_rdy[2]), .in_a(xa), .in_b(xb),
    .abort(1'b0), .out_valid(x_ov[2]), .out_ready(1'b1), .out_z(x_z[2]), .busy(x_busy[2]));
  gf_mult_seq #(.DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(xv), .in_ready(x_rdy[3]), .in_a(xa), .in_b(xb),
    .abort(1'b0), .out_valid(x_ov[3]), .out_ready(1'b1), .out_z(x_z[3]), .busy(x_busy[3]));
  gf_mult_seq #(.REFLECT(1'b1)) u_r8 (
    .clk(clk), .rst_n(rst_n), .in_valid(xv), .in_ready(x_rdy[4]), .in_a(xra), .in_b(xrb),
    .abort(1'b0), .out_valid(x_ov[4]), .out_ready(1'b1), .out_z(x_z[4]), .busy(x_busy[4]));

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W); i++) r[i] = v[int'(W) - 1 - i];
    return r;
  endfunction

  // Reference: LSB-first shift-and-add over the multiplier bits.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] z, bb;
    z = '0;
    bb = b;
    for (int i = 0; i < int'(W); i++) begin
      if (a[i]) z = z ^ bb;
      bb = {bb[W-2:0], 1'b0} ^ (bb[W-1] ? P : '0);
    end
    return z;
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge after the accept edge; returns edges counted until out_valid.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                        output logic [W-1:0] z, output int lat);
    start_op(a, b);
    wait_done(lat);
    repeat (stall) begin @(posedge clk); @(negedge clk); end
    z = out_z;
    finish_op();
  endtask

  int aux_lat [5];
  logic [W-1:0] aux_z [5];

  task automatic run_aux(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ra, input logic [W-1:0] rb);
    logic [4:0] seen;
    int n;
    @(negedge clk);
    xa = a; xb = b; xra = ra; xrb = rb; xv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    xv = 1'b0;
    seen = '0;
    n = 0;
    for (int k = 0; k < 5; k++) begin aux_lat[k] = -1; aux_z[k] = 'x; end
    while (seen != 5'h1F && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      for (int k = 0; k < 5; k++)
        if (!seen[k] && x_ov[k]) begin seen[k] = 1'b1; aux_lat[k] = n; aux_z[k] = x_z[k]; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z;
  } vec_t;

  vec_t tv [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] z, zsnap, a1, b1, a2, b2;
    int lat, gap, stall;
    bit ok, seen_ov;
    int exp_lat [5];

    tv[0] = '{128'h1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
              128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    tv[1] = '{X127, 128'h2, 128'h87};
    tv[2] = '{128'h1_0000_0000_0000_0000, 128'h1_0000_0000_0000_0000, 128'h87};
    tv[3] = '{X127, X127, SQ127};
    tv[4] = '{128'h3, 128'h5, 128'hF};
    tv[5] = '{128'h0, {W{1'b1}}, 128'h0};
    tv[6] = '{X127 | 128'h1, 128'h2, 128'h85};
    tv[7] = '{128'h8, 128'h2000_0000_0000_0000_0000_0000_0000_0000, 128'h87};
    exp_lat[0] = 128; exp_lat[1] = 64; exp_lat[2] = 32; exp_lat[3] = 8; exp_lat[4] = 16;

    // Reset with in_valid high: nothing may be accepted.
    rst_n = 1'b0; in_valid = 1'b1; in_a = 128'h3; in_b = 128'h5;
    abort = 1'b0; out_ready = 1'b0;
    xv = 1'b0; xa = '0; xb = '0; xra = '0; xrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_busy", W'(busy), W'(0));
    check("reset_out_z", out_z, '0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_idle", W'(busy), W'(0));

    for (int i = 0; i < 8; i++) begin
      run_op(tv[i].a, tv[i].b, 0, z, lat);
      check($sformatf("vec%0d_z", i), z, tv[i].z);
      check($sformatf("vec%0d_lat", i), W'(lat), W'(16));
    end

    // Backpressure in DONE, with a second pair offered that must wait.
    a1 = rnd128(); b1 = rnd128(); a2 = rnd128(); b2 = rnd128();
    start_op(a1, b1);
    wait_done(lat);
    zsnap = out_z;
    check("bp_first_z", zsnap, model(a1, b1));
    in_a = a2; in_b = b2; in_valid = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (out_z !== zsnap || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    check("bp_hold_stable", W'(ok), W'(1));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_after_handshake", {in_ready, busy, out_valid}, W'(3'b100));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accept_next", {in_ready, busy}, W'(2'b01));
    wait_done(lat);
    check("bp_second_z", out_z, model(a2, b2));
    check("bp_second_lat", W'(lat), W'(16));
    finish_op();

    // Abort five edges after accept.
    start_op(rnd128(), rnd128());
    repeat (4) begin @(posedge clk); @(negedge clk); end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_idle", {in_ready, busy, out_valid}, W'(3'b100));
    seen_ov = 1'b0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen_ov = 1'b1;
    end
    check("abort_no_result", W'(seen_ov), W'(0));

    // Abort in IDLE must not block an accept on the same edge.
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b1; in_a = tv[4].a; in_b = tv[4].b;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("idle_abort_accepted", W'(busy), W'(1));
    wait_done(lat);
    check("idle_abort_z", out_z, tv[4].z);
    finish_op();

    // Abort together with out_ready in DONE discards the result.
    start_op(tv[1].a, tv[1].b);
    wait_done(lat);
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    check("done_abort_idle", {in_ready, busy, out_valid}, W'(3'b100));
    check("done_abort_z_zero", out_z, '0);

    // Asynchronous reset in the middle of BUSY.
    start_op(rnd128(), rnd128());
    repeat (3) begin @(posedge clk); @(negedge clk); end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {in_ready, busy, out_valid}, W'(3'b100));
    check("async_reset_out_z", out_z, '0);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    check("reset_ignores_in_valid", W'(busy), W'(0));
    run_op(tv[3].a, tv[3].b, 0, z, lat);
    check("after_reset_z", z, tv[3].z);
    check("after_reset_lat", W'(lat), W'(16));

    // Other DIGIT values and reflected bit order.
    run_aux(X127, X127, 128'h1, 128'h1);
    for (int k = 0; k < 4; k++) check($sformatf("sq127_d%0d_z", k), aux_z[k], SQ127);
    check("sq127_reflect_z", aux_z[4], rev(SQ127));
    for (int k = 0; k < 5; k++) check($sformatf("aux%0d_lat", k), W'(aux_lat[k]), W'(exp_lat[k]));
    run_aux(128'h1, tv[0].b, X127, tv[0].b);
    for (int k = 0; k < 5; k++) check($sformatf("one_aux%0d_z", k), aux_z[k], tv[0].b);
    for (int r = 0; r < 10; r++) begin
      a1 = rnd128(); b1 = rnd128(); a2 = rnd128(); b2 = rnd128();
      run_aux(a1, b1, a2, b2);
      for (int k = 0; k < 4; k++) check($sformatf("rnd_aux%0d_z", k), aux_z[k], model(a1, b1));
      check("rnd_reflect_z", aux_z[4], rev(model(rev(a2), rev(b2))));
    end

    // Random operands with random idle gaps and output stalls.
    for (int r = 0; r < 200; r++) begin
      gap = $urandom_range(0, 3);
      stall = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      a1 = rnd128(); b1 = rnd128();
      run_op(a1, b1, stall, z, lat);
      check("rnd_main_z", z, model(a1, b1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
